// File: rtl/toggle_pkg.sv
// Shared definitions for the push-button conditioning stage feeding the T flip-flop.
package toggle_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int PRESS_COUNT_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; clears to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/toggle_debounce.sv
// Debounces a raw push-button into a one-cycle toggle request, a clean level and a press count.
// Optional auto-repeat while held is enabled by defining TOGGLE_AUTO_REPEAT_EN.
module toggle_debounce
   import toggle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     btn_in,
   output logic                     t_pulse,
   output logic                     btn_level,
   output logic [PRESS_COUNT_W-1:0] press_count
);

   localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef TOGGLE_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   logic                     btn_sync;
   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic                     t_pulse_nxt;
   logic                     btn_level_nxt;
   logic [PRESS_COUNT_W-1:0] press_count_nxt;

   sync_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (btn_in),
      .q       (btn_sync)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         t_pulse     <= 1'b0;
         btn_level   <= 1'b0;
         press_count <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         t_pulse     <= t_pulse_nxt;
         btn_level   <= btn_level_nxt;
         press_count <= press_count_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      t_pulse_nxt     = 1'b0;
      btn_level_nxt   = btn_level;
      press_count_nxt = press_count;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (btn_sync) state_nxt = PRESS_WAIT;
         end

         PRESS_WAIT: begin
            if (!btn_sync) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt       = PRESSED;
               cnt_nxt         = '0;
               t_pulse_nxt     = 1'b1;
               btn_level_nxt   = 1'b1;
               press_count_nxt = press_count + PRESS_COUNT_W'(1);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         PRESSED: begin
            if (!btn_sync) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end else begin
`ifdef TOGGLE_AUTO_REPEAT_EN
               // Held button: emit a repeat toggle every REPEAT_CYCLES edges.
               if (cnt == REP_LAST) begin
                  cnt_nxt         = '0;
                  t_pulse_nxt     = 1'b1;
                  press_count_nxt = press_count + PRESS_COUNT_W'(1);
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
`else
               cnt_nxt = '0;
`endif
            end
         end

         RELEASE_WAIT: begin
            if (btn_sync) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               btn_level_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: doc/toggle_debounce.md
# toggle_debounce

Upstream conditioning stage for the synchronous T flip-flop. It takes a raw, asynchronous, bouncing push-button level and produces a clean single-cycle `t_pulse` that drives the flip-flop's `t` input. It also provides a debounced button level and a wrapping count of accepted presses for status display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a press or a release. Must be at least 2.
- `REPEAT_CYCLES`, default 64: hold interval between auto-repeat pulses. Used only when `TOGGLE_AUTO_REPEAT_EN` is defined.
- `CNT_W`, derived: `$clog2` of the larger of `DEBOUNCE_CYCLES` and `REPEAT_CYCLES`, plus 1.

Ports:
- `clk`  input  1  single clock for the whole block.
- `reset_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `btn_in`  input  1  raw asynchronous button level, 1 = pressed.
- `t_pulse`  output  1  registered one-cycle toggle request, fed to the T flip-flop's `t` input.
- `btn_level`  output  1  registered debounced button level.
- `press_count`  output  8  registered count of accepted presses; wraps from 255 to 0.

## Operation
- Two-flop synchronizer: `btn_in` passes through two flops to give `btn_sync`. Nothing downstream uses `btn_in` directly.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. One counter `cnt` of width `CNT_W` is shared by all states.
- IDLE (`btn_level` = 0):
  - `btn_sync` = 1 → go to PRESS_WAIT and set `cnt` to 0.
- PRESS_WAIT:
  - `btn_sync` = 0 → return to IDLE. This is a rejected bounce: no pulse, no count.
  - `btn_sync` = 1 and `cnt` = `DEBOUNCE_CYCLES`−1 → go to PRESSED, set `cnt` to 0, and register `t_pulse` = 1, `btn_level` = 1, `press_count`+1.
  - Otherwise → `cnt`+1.
- PRESSED (`btn_level` = 1):
  - `btn_sync` = 0 → go to RELEASE_WAIT and set `cnt` to 0.
  - Auto-repeat behaviour: see Configuration.
- RELEASE_WAIT:
  - `btn_sync` = 1 → return to PRESSED. No pulse is produced.
  - `btn_sync` = 0 and `cnt` = `DEBOUNCE_CYCLES`−1 → go to IDLE and register `btn_level` = 0. No pulse on release.
  - Otherwise → `cnt`+1.
- `t_pulse` is high for exactly one cycle per accepted event and is never high on two consecutive cycles.
- `press_count` increments exactly once per accepted press, plus once per auto-repeat pulse when that feature is enabled.
- `press_count` arithmetic is modulo 256.

## Timing
- Reset values:
  - `t_pulse` = 0, `btn_level` = 0, `press_count` = 0.
  - State = IDLE, `cnt` = 0, both synchronizer flops = 0.
- Press latency: `t_pulse` goes high immediately after the `DEBOUNCE_CYCLES`+3-th rising edge, counting the first edge that samples `btn_in` high as edge 1. The breakdown is:
  - 2 edges for the synchronizer,
  - 1 edge for IDLE→PRESS_WAIT,
  - `DEBOUNCE_CYCLES` edges of counting.
- Release latency: `btn_level` falls after the same `DEBOUNCE_CYCLES`+3 edges.
- Any low synchronized sample during PRESS_WAIT restarts acceptance from IDLE. The same applies symmetrically to high samples during RELEASE_WAIT.
- Reset asserted mid-operation:
  - All state clears on that edge, and any pending pulse is dropped.
  - If the button is still held when reset deasserts, a fresh full-latency press is accepted.
- Reset has priority over every other condition on every edge.

## Configuration
- Macro: `TOGGLE_AUTO_REPEAT_EN`.
- Defined:
  - In PRESSED with `btn_sync` = 1, `cnt` counts up.
  - When `cnt` = `REPEAT_CYCLES`−1, the block registers `t_pulse` = 1 and `press_count`+1, and sets `cnt` to 0.
  - The first repeat pulse occurs `REPEAT_CYCLES` edges after the press pulse.
  - The release path is unchanged.
- Not defined:
  - PRESSED holds `cnt` at 0, and at most one pulse is produced per press.
  - `REPEAT_CYCLES` is ignored.

## Structure
- Shared package `toggle_pkg`:
  - State encoding constants for IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT: 2 bits, values 0–3 in that order.
  - `PRESS_COUNT_W` = 8.
- Sub-module `sync_2ff`: a two-flop synchronizer with `clk`, `reset_n`, `d`, `q`. It resets to 0 and is reused by other input stages.
- All outputs are driven directly from flops. No combinational paths from inputs to outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `REPEAT_CYCLES` = 8.
- Clean press: `btn_in` 0→1 and held → `t_pulse` high for one cycle after edge 7, `btn_level` = 1 from the same cycle, `press_count` = 1.
- Bounce: `btn_in` pattern 1,0,1,1,0 sampled on successive edges, then held 0 → `t_pulse` never asserts, `press_count` stays 0.
- Release: press accepted, then `btn_in` held 0 → `btn_level` falls after edge 7 of release, no `t_pulse`. A glitch high 2 cycles into the release returns to PRESSED with `btn_level` still 1.
- Reset mid-PRESS_WAIT: `reset_n` low for 1 edge at edge 5 of a press with button held → no pulse at edge 7, pulse after edge 7 counted from the deassertion edge, `press_count` = 1.
- Wrap: 256 accepted presses → `press_count` = 0, and 256 single-cycle `t_pulse`s are counted.
- `TOGGLE_AUTO_REPEAT_EN` defined, button held 30 edges after acceptance → extra pulses 8, 16, and 24 edges after the press pulse, `press_count` = 4. Same stimulus with the macro undefined → `press_count` = 1.
